// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - mode encodings and channel-select width helper for multi_timer
package multi_timer_pkg;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  function automatic int ch_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel (free-run up, periodic down, one-shot down)
// Optional sticky interrupt flop is built only when MULTI_TIMER_IRQ_EN is defined.
module timer_channel import multi_timer_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_step,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_mode,
  input  logic [WIDTH-1:0] i_cfg_reload,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_irq_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_running,
  output logic             o_tick,
  output logic             o_irq
);

  mode_e            r_mode;
  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_count;
  logic             r_running;
  logic             r_tick;

  logic [WIDTH-1:0] w_next;
  logic             w_expire;
  logic             w_fire;
  logic             w_cfg_down;

  assign w_fire     = i_step && r_running;
  assign w_cfg_down = (i_cfg_mode == MODE_PERIODIC) || (i_cfg_mode == MODE_ONESHOT);

  always_comb begin
    w_next   = r_count;
    w_expire = 1'b0;
    case (r_mode)
      MODE_PERIODIC: begin
        if (r_count == '0) begin
          w_next   = r_reload;
          w_expire = 1'b1;
        end else begin
          w_next = r_count - 1'b1;
        end
      end
      MODE_ONESHOT: begin
        if (r_count == '0) begin
          w_expire = 1'b1;
        end else begin
          w_next = r_count - 1'b1;
        end
      end
      // free-run and the reserved encoding share the up-counter path
      default: begin
        if ((r_count == r_reload) || (r_count == '1)) begin
          w_next   = '0;
          w_expire = 1'b1;
        end else begin
          w_next = r_count + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode    <= MODE_FREE;
      r_reload  <= '0;
      r_count   <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
    end else if (i_cfg_we) begin
      r_mode    <= mode_e'(i_cfg_mode);
      r_reload  <= i_cfg_reload;
      r_count   <= w_cfg_down ? i_cfg_reload : '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_tick <= w_fire && w_expire;
      if (w_fire) begin
        r_count <= w_next;
      end
      if (i_stop) begin
        r_running <= 1'b0;
      end else if (i_start) begin
        r_running <= 1'b1;
      end else if (w_fire && w_expire && (r_mode == MODE_ONESHOT)) begin
        r_running <= 1'b0;
      end
    end
  end

  assign o_count   = r_count;
  assign o_running = r_running;
  assign o_tick    = r_tick;

`ifdef MULTI_TIMER_IRQ_EN
  logic r_irq;

  // a new tick beats a clear arriving in the same cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_irq <= 1'b0;
    end else if (r_tick) begin
      r_irq <= 1'b1;
    end else if (i_irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign o_irq = r_irq;
`else
  logic w_unused_irq_clr;

  assign w_unused_irq_clr = i_irq_clr;
  assign o_irq            = 1'b0;
`endif

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - NUM_CH independent timers sharing one prescaler step
// Sticky per-channel irq flags exist only when MULTI_TIMER_IRQ_EN is defined.
module multi_timer import multi_timer_pkg::*; #(
  parameter int WIDTH   = 32,
  parameter int NUM_CH  = 2,
  parameter int PRESC_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        presc_we,
  input  logic [PRESC_W-1:0]          presc_val,
  input  logic                        cfg_we,
  input  logic [ch_sel_w(NUM_CH)-1:0] cfg_ch,
  input  logic [1:0]                  cfg_mode,
  input  logic [WIDTH-1:0]            cfg_reload,
  input  logic [NUM_CH-1:0]           start,
  input  logic [NUM_CH-1:0]           stop,
  input  logic [NUM_CH-1:0]           irq_clr,
  output logic [NUM_CH*WIDTH-1:0]     count,
  output logic [NUM_CH-1:0]           running,
  output logic [NUM_CH-1:0]           tick,
  output logic [NUM_CH-1:0]           irq
);

  localparam int CH_W = ch_sel_w(NUM_CH);

  logic [PRESC_W-1:0] r_presc_val;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic               w_step;

  // a prescaler write restarts the divide window, so that cycle never steps
  assign w_step = !presc_we && (r_presc_cnt == r_presc_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc_val <= '0;
      r_presc_cnt <= '0;
    end else if (presc_we) begin
      r_presc_val <= presc_val;
      r_presc_cnt <= '0;
    end else if (w_step) begin
      r_presc_cnt <= '0;
    end else begin
      r_presc_cnt <= r_presc_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic w_cfg_sel;

    assign w_cfg_sel = cfg_we && (cfg_ch == CH_W'(gi));

    timer_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .i_clk        (clk),
      .i_rst_n      (reset),
      .i_step       (w_step),
      .i_cfg_we     (w_cfg_sel),
      .i_cfg_mode   (cfg_mode),
      .i_cfg_reload (cfg_reload),
      .i_start      (start[gi]),
      .i_stop       (stop[gi]),
      .i_irq_clr    (irq_clr[gi]),
      .o_count      (count[gi*WIDTH +: WIDTH]),
      .o_running    (running[gi]),
      .o_tick       (tick[gi]),
      .o_irq        (irq[gi])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed self-checking bench for multi_timer
module tb_multi_timer;

`ifdef MULTI_TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        presc_we;
  logic [7:0]  presc_val;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_reload;
  logic [1:0]  start;
  logic [1:0]  stop;
  logic [1:0]  irq_clr;
  logic [63:0] count;
  logic [1:0]  running;
  logic [1:0]  tick;
  logic [1:0]  irq;

  int n_tests = 0;
  int n_fail  = 0;

  multi_timer dut (
    .clk        (clk),
    .reset      (reset),
    .presc_we   (presc_we),
    .presc_val  (presc_val),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_reload (cfg_reload),
    .start      (start),
    .stop       (stop),
    .irq_clr    (irq_clr),
    .count      (count),
    .running    (running),
    .tick       (tick),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic ch, input logic [1:0] mode, input logic [31:0] rl);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_reload = rl;
    adv(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; presc_we = 1'b0; presc_val = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_mode = '0; cfg_reload = '0; start = '0; stop = '0; irq_clr = '0;
    adv(2);
    chk("rst_count", count, 64'd0);
    chk("rst_running", {62'd0, running}, 64'd0);
    chk("rst_tick", {62'd0, tick}, 64'd0);
    chk("rst_irq", {62'd0, irq}, 64'd0);
    reset = 1'b1;
    adv(1);

    // prescale by 4, free-run up to 5
    presc_we = 1'b1; presc_val = 8'd3;
    cfg(1'b0, 2'd0, 32'd5);
    presc_we = 1'b0;
    chk("fr_cfg_count", {32'd0, count[31:0]}, 64'd0);
    start = 2'b01; adv(1); start = 2'b00;
    chk("fr_running", {62'd0, running}, 64'd1);
    adv(2);
    chk("fr_e3_count", {32'd0, count[31:0]}, 64'd0);
    adv(1);
    chk("fr_e4_count", {32'd0, count[31:0]}, 64'd1);
    adv(4);
    chk("fr_e8_count", {32'd0, count[31:0]}, 64'd2);
    adv(12);
    chk("fr_e20_count", {32'd0, count[31:0]}, 64'd5);
    chk("fr_e20_tick", {62'd0, tick}, 64'd0);
    adv(3);
    chk("fr_e23_count", {32'd0, count[31:0]}, 64'd5);
    adv(1);
    chk("fr_e24_count", {32'd0, count[31:0]}, 64'd0);
    chk("fr_e24_tick", {62'd0, tick}, 64'd1);
    adv(1);
    chk("fr_e25_tick", {62'd0, tick}, 64'd0);
    adv(23);
    chk("fr_e48_tick", {62'd0, tick}, 64'd1);
    stop = 2'b01; presc_we = 1'b1; presc_val = 8'd0;
    adv(1);
    stop = 2'b00; presc_we = 1'b0;
    chk("fr_stop_running", {62'd0, running}, 64'd0);
    chk("fr_stop_count", {32'd0, count[31:0]}, 64'd0);

    // periodic down on ch1, prescaler off
    cfg(1'b1, 2'd1, 32'd2);
    chk("pd_cfg_count", {32'd0, count[63:32]}, 64'd2);
    start = 2'b10; adv(1); start = 2'b00;
    chk("pd_running", {62'd0, running}, 64'd2);
    chk("pd_s0_count", {32'd0, count[63:32]}, 64'd2);
    adv(1);
    chk("pd_s1_count", {32'd0, count[63:32]}, 64'd1);
    adv(1);
    chk("pd_s2_count", {32'd0, count[63:32]}, 64'd0);
    chk("pd_s2_tick", {62'd0, tick}, 64'd0);
    adv(1);
    chk("pd_s3_count", {32'd0, count[63:32]}, 64'd2);
    chk("pd_s3_tick", {62'd0, tick}, 64'd2);
    adv(1);
    chk("pd_s4_count", {32'd0, count[63:32]}, 64'd1);
    chk("pd_s4_tick", {62'd0, tick}, 64'd0);
    adv(2);
    chk("pd_s6_tick", {62'd0, tick}, 64'd2);
    chk("pd_ch0_count", {32'd0, count[31:0]}, 64'd0);
    chk("pd_ch0_running", {63'd0, running[0]}, 64'd0);
    stop = 2'b10; adv(1); stop = 2'b00;

    // one-shot down on ch0
    cfg(1'b0, 2'd2, 32'd4);
    chk("os_cfg_count", {32'd0, count[31:0]}, 64'd4);
    start = 2'b01; adv(1); start = 2'b00;
    chk("os_running", {62'd0, running}, 64'd1);
    adv(4);
    chk("os_s4_count", {32'd0, count[31:0]}, 64'd0);
    chk("os_s4_running", {62'd0, running}, 64'd1);
    chk("os_s4_tick", {62'd0, tick}, 64'd0);
    adv(1);
    chk("os_s5_tick", {62'd0, tick}, 64'd1);
    chk("os_s5_running", {62'd0, running}, 64'd0);
    chk("os_s5_count", {32'd0, count[31:0]}, 64'd0);
    adv(1);
    chk("os_s6_tick", {62'd0, tick}, 64'd0);
    chk("os_s6_count", {32'd0, count[31:0]}, 64'd0);

    // interrupt set/clear priority on ch1
    cfg(1'b1, 2'd1, 32'd2);
    start = 2'b10; adv(1); start = 2'b00;
    adv(3);
    chk("irq_s3_tick", {62'd0, tick}, 64'd2);
    adv(1);
    chk("irq_set", {62'd0, irq}, {62'd0, IRQ_ON, 1'b0});
    adv(2);
    chk("irq_s6_tick", {62'd0, tick}, 64'd2);
    irq_clr = 2'b10;
    adv(1);
    chk("irq_clr_vs_tick", {62'd0, irq}, {62'd0, IRQ_ON, 1'b0});
    adv(1);
    irq_clr = 2'b00;
    chk("irq_clr_alone", {62'd0, irq}, 64'd0);
    stop = 2'b10; adv(1); stop = 2'b00;

    // start and stop together, then reset mid-count
    cfg(1'b0, 2'd0, 32'd10);
    start = 2'b01; stop = 2'b01; adv(1); start = 2'b00; stop = 2'b00;
    chk("ss_running", {62'd0, running}, 64'd0);
    chk("ss_count", {32'd0, count[31:0]}, 64'd0);
    adv(1);
    chk("ss_count_hold", {32'd0, count[31:0]}, 64'd0);
    start = 2'b11; adv(1); start = 2'b00;
    adv(3);
    chk("mid_count", {32'd0, count[31:0]}, 64'd3);
    chk("mid_running", {62'd0, running}, 64'd3);
    #3 reset = 1'b0;
    #1;
    chk("arst_count", count, 64'd0);
    chk("arst_running", {62'd0, running}, 64'd0);
    chk("arst_tick", {62'd0, tick}, 64'd0);
    chk("arst_irq", {62'd0, irq}, 64'd0);
    adv(1);
    reset = 1'b1;
    adv(1);
    chk("post_rst_tick", {62'd0, tick}, 64'd0);
    chk("post_rst_running", {62'd0, running}, 64'd0);
    adv(3);
    chk("post_rst_count", count, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: counter width per channel.
REQ-002 SHALL have parameter NUM_CH, default 2: number of independent channels.
REQ-003 SHALL have parameter PRESC_W, default 8: shared prescaler width.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port presc_we  input  1: prescaler value write strobe.
REQ-007 SHALL have port presc_val  input  PRESC_W: prescale divisor minus one.
REQ-008 SHALL have port cfg_we  input  1: channel configuration write strobe.
REQ-009 SHALL have port cfg_ch  input  max(1,clog2(NUM_CH)): channel selected by cfg_we.
REQ-010 SHALL have port cfg_mode  input  2: 0 free-run up, 1 periodic down, 2 one-shot down, 3 reserved (treated as 0).
REQ-011 SHALL have port cfg_reload  input  WIDTH: reload/terminal value.
REQ-012 SHALL have ports start, stop, irq_clr  input  NUM_CH each: per-channel one-cycle strobes.
REQ-013 SHALL have port count  output  NUM_CH*WIDTH: channel i count at bits [i*WIDTH +: WIDTH].
REQ-014 SHALL have ports running, tick, irq  output  NUM_CH each: run state, one-cycle event pulse, sticky interrupt.

Function
REQ-015 Prescaler SHALL count 0..presc_val and assert internal step for one cycle when it equals presc_val, then return to 0; presc_val=0 gives step every cycle.
REQ-016 presc_we SHALL load presc_val and clear the prescaler count in the same cycle; no step is issued that cycle.
REQ-017 cfg_we SHALL load mode and reload for cfg_ch, set count to 0 (mode 0) or reload (modes 1,2), clear running; it overrides any step that cycle.
REQ-018 start SHALL set running from the next cycle; stop SHALL clear it; start and stop together SHALL leave running cleared (stop wins).
REQ-019 Mode 0: on step while running, count SHALL increment; at count==reload, next step SHALL set count to 0 and pulse tick; WIDTH wrap from all-ones to 0 also pulses tick.
REQ-020 Mode 1: on step while running, count SHALL decrement; at count==0, next step SHALL load reload and pulse tick; reload=0 gives tick on every step.
REQ-021 Mode 2: as mode 1 but at count==0 the next step SHALL pulse tick, leave count at 0 and clear running.
REQ-022 tick SHALL be registered, high exactly one cycle per event, never high when the channel is not running before that step.
REQ-023 Channels SHALL be fully independent except for the shared step.

Reset
REQ-024 reset low SHALL immediately force count=0, running=0, tick=0, irq=0, mode=0, reload=0, presc_val=0, prescaler count=0.
REQ-025 reset asserted mid-count SHALL abort all channels; no tick is emitted on deassertion.

Configuration
REQ-026 With MULTI_TIMER_IRQ_EN defined, irq[i] SHALL set on tick[i] and clear on irq_clr[i]; simultaneous set and clear SHALL leave irq set.
REQ-027 Without MULTI_TIMER_IRQ_EN, irq SHALL be constant 0 and irq_clr ignored; no irq flops are synthesised.

Structure
REQ-028 Package multi_timer_pkg SHALL hold the mode encodings (MODE_FREE, MODE_PERIODIC, MODE_ONESHOT) and the channel-select width function.
REQ-029 Per-channel logic SHALL be sub-module timer_channel, instantiated NUM_CH times by generate; prescaler stays in multi_timer.

Verification
REQ-030 presc_val=3, ch0 mode 0 reload=5, start -> count steps every 4 cycles 0..5, tick at 5->0 transition, period 24 cycles.
REQ-031 presc_val=0, ch1 mode 1 reload=2, start -> count 2,1,0,2,..., tick every 3 cycles; ch0 unaffected.
REQ-032 presc_val=0, ch0 mode 2 reload=4, start -> single tick 5 cycles after running, running drops same edge, count holds 0.
REQ-033 start and stop same cycle on ch0 -> running stays 0, count unchanged; reset low mid-count -> all outputs 0 immediately.
REQ-034 MULTI_TIMER_IRQ_EN defined, tick and irq_clr same cycle -> irq stays 1; irq_clr alone next cycle -> irq 0; undefined -> irq always 0.
